// File: rtl/ir_consts_pkg.sv
// Shared constants for the IR command path: the register map, the watchdog
// state encoding and the reset timeout.
package ir_consts;

  localparam logic [2:0] IR_REG_CMD    = 3'd0;
  localparam logic [2:0] IR_REG_CAR    = 3'd1;
  localparam logic [2:0] IR_REG_CTRL   = 3'd2;
  localparam logic [2:0] IR_REG_STATUS = 3'd3;
  localparam logic [2:0] IR_REG_TMO    = 3'd4;

  // Highest decoded offset from the block's base address.
  localparam logic [7:0] IR_REG_LAST   = 8'd4;

  localparam logic [7:0] IR_TMO_RESET  = 8'd100;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_EXPIRED = 2'd2
  } wd_state_e;

endpackage

// File: rtl/ir_ms_ticker.sv
// Free-running prescaler: counts 0..TICK_CYCLES-1 and pulses tick for one
// cycle on the wrap.
module ir_ms_ticker #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ir_command_regs.sv
// Byte-wide register block feeding the IR transmitter, with a millisecond
// watchdog that stops the car when software stops refreshing COMMAND.
module ir_command_regs
  import ir_consts::*;
#(
  parameter logic [7:0] BASE_ADDR       = 8'h90,
  parameter int         CMD_LEN         = 4,
  parameter int         CAR_COUNT       = 4,
  parameter int         SYS_CLK_FREQ_HZ = 50_000_000,
  parameter int         TICK_CYCLES     = SYS_CLK_FREQ_HZ / 1000,
  localparam int        CAR_W           = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         BUS_ADDR,
  input  logic [7:0]         BUS_WDATA,
  input  logic               BUS_WE,
  input  logic               BUS_RE,
  output logic [7:0]         BUS_RDATA,
  output logic               BUS_RVALID,
  output logic [CMD_LEN-1:0] COMMAND,
  output logic [CAR_W-1:0]   CAR_SWITCHES,
  output logic               TIMEOUT_IRQ,
  output wd_state_e          debug_state
);

  // Bus protocol: BUS_WE and BUS_RE are single-cycle strobes with no ready
  // (the block always accepts). A write commits on the sampling edge; a read
  // returns BUS_RDATA with BUS_RVALID=1 exactly one cycle later, both 0 at all
  // other times. A read in the same cycle as a write returns the old value.

  logic [8:0] addr_off;
  logic       in_range;
  logic [2:0] reg_sel;

  assign addr_off = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign in_range = !addr_off[8] && (addr_off[7:0] <= IR_REG_LAST);
  assign reg_sel  = addr_off[2:0];

  logic cmd_wr, car_wr, ctrl_wr, tmo_wr, ack_wr, rd_hit;

  assign cmd_wr  = BUS_WE && in_range && (reg_sel == IR_REG_CMD);
  assign car_wr  = BUS_WE && in_range && (reg_sel == IR_REG_CAR);
  assign ctrl_wr = BUS_WE && in_range && (reg_sel == IR_REG_CTRL);
  assign tmo_wr  = BUS_WE && in_range && (reg_sel == IR_REG_TMO);
  assign ack_wr  = ctrl_wr && BUS_WDATA[1];
  assign rd_hit  = BUS_RE && in_range;

  logic [CMD_LEN-1:0] command_q;
  logic [CAR_W-1:0]   car_q;
  logic               wdog_en_q;
  logic [7:0]         tmo_q;
  logic               flag_q;
  logic [7:0]         ms_cnt_q, ms_cnt_d;
  wd_state_e          state_q, state_d;
  logic               tick;

  ir_ms_ticker #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_ticker (
    .clk  (CLK),
    .rst_n(RESET),
    .tick (tick)
  );

  logic wd_active, reach, expire;

  assign wd_active = wdog_en_q && (tmo_q != 8'd0);
  // Compare against the incremented count so a TMO lowered below the current
  // count still expires on the very next tick.
  assign reach     = ({1'b0, ms_cnt_q} + 9'd1) >= {1'b0, tmo_q};
  assign expire    = (state_q == WD_ARMED) && wd_active && tick && !cmd_wr && reach;

  always_comb begin
    state_d = state_q;
    if (!wd_active) begin
      state_d = WD_IDLE;
    end else begin
      case (state_q)
        WD_IDLE:    state_d = WD_ARMED;
        WD_ARMED:   if (expire) state_d = WD_EXPIRED;
        WD_EXPIRED: if (cmd_wr) state_d = WD_ARMED;
        default:    state_d = WD_IDLE;
      endcase
    end
  end

  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if ((state_q != WD_ARMED) || !wd_active || cmd_wr) begin
      ms_cnt_d = '0;
    end else if (tick) begin
      ms_cnt_d = ms_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= WD_IDLE;
      ms_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      command_q <= '0;
    end else if (cmd_wr) begin
      command_q <= BUS_WDATA[CMD_LEN-1:0];
    end else if (expire) begin
      command_q <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      car_q     <= '0;
      wdog_en_q <= 1'b0;
      tmo_q     <= IR_TMO_RESET;
    end else begin
      if (car_wr)  car_q     <= BUS_WDATA[CAR_W-1:0];
      if (ctrl_wr) wdog_en_q <= BUS_WDATA[0];
      if (tmo_wr)  tmo_q     <= BUS_WDATA;
    end
  end

  // A fresh expiry outranks an ACK landing on the same edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flag_q <= 1'b0;
    end else if (expire) begin
      flag_q <= 1'b1;
    end else if (ack_wr) begin
      flag_q <= 1'b0;
    end
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      IR_REG_CMD:    rd_mux = 8'(command_q);
      IR_REG_CAR:    rd_mux = 8'(car_q);
      IR_REG_CTRL:   rd_mux = {7'd0, wdog_en_q};
      IR_REG_STATUS: rd_mux = {6'd0, (state_q == WD_ARMED), flag_q};
      IR_REG_TMO:    rd_mux = tmo_q;
      default:       rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BUS_RDATA  <= 8'h00;
      BUS_RVALID <= 1'b0;
    end else begin
      BUS_RVALID <= rd_hit;
      BUS_RDATA  <= rd_hit ? rd_mux : 8'h00;
    end
  end

  assign COMMAND      = command_q;
  assign CAR_SWITCHES = car_q;
  assign TIMEOUT_IRQ  = flag_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_ir_command_regs.sv
// Directed bench for ir_command_regs with a 10-cycle millisecond tick.
module tb_ir_command_regs;
  import ir_consts::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_WDATA = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       BUS_RE = 1'b0;
  logic [7:0] BUS_RDATA;
  logic       BUS_RVALID;
  logic [3:0] COMMAND;
  logic [1:0] CAR_SWITCHES;
  logic       TIMEOUT_IRQ;
  wd_state_e  debug_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ir_command_regs #(
    .BASE_ADDR  (8'h90),
    .CMD_LEN    (4),
    .CAR_COUNT  (4),
    .TICK_CYCLES(10)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_WDATA   (BUS_WDATA),
    .BUS_WE      (BUS_WE),
    .BUS_RE      (BUS_RE),
    .BUS_RDATA   (BUS_RDATA),
    .BUS_RVALID  (BUS_RVALID),
    .COMMAND     (COMMAND),
    .CAR_SWITCHES(CAR_SWITCHES),
    .TIMEOUT_IRQ (TIMEOUT_IRQ),
    .debug_state (debug_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // Edge count since reset release: after rising edge k, cyc == k.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WDATA = d; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic v);
    BUS_ADDR = a; BUS_RE = 1'b1;
    @(negedge CLK);
    BUS_RE = 1'b0;
    d = BUS_RDATA; v = BUS_RVALID;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (cyc != target) begin
      vectors++; miscompares++;
      $display("FAIL wait_cyc: got cycle %0d required %0d", cyc, target);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    logic       v;
    logic [7:0] exp_rd [5];
    exp_rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h64};
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    bus_write(8'h90, 8'h05);
    bus_write(8'h91, 8'h01);
    vectors++;
    if (COMMAND !== 4'h5 || CAR_SWITCHES !== 2'd1) begin
      miscompares++;
      $display("FAIL pre_reset_write: got cmd=%h car=%h required cmd=5 car=1", COMMAND, CAR_SWITCHES);
    end
    #2 RESET = 1'b0;
    #1;
    vectors++;
    if (COMMAND !== 4'h0 || CAR_SWITCHES !== 2'd0 || TIMEOUT_IRQ !== 1'b0 || BUS_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got cmd=%h car=%h irq=%b rvalid=%b required all 0",
               COMMAND, CAR_SWITCHES, TIMEOUT_IRQ, BUS_RVALID);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_read(8'h90 + 8'(i), d, v);
      vectors++;
      if (v !== 1'b1 || d !== exp_rd[i]) begin
        miscompares++;
        $display("FAIL reset_read_%0d: got v=%b d=%h required v=1 d=%h", i, v, d, exp_rd[i]);
      end
    end
  endtask

  task automatic test_writes();
    logic [7:0] d;
    logic       v;
    bus_write(8'h90, 8'hF3);
    vectors++;
    if (COMMAND !== 4'h3) begin
      miscompares++;
      $display("FAIL cmd_write: got %h required 3", COMMAND);
    end
    bus_write(8'h91, 8'h06);
    vectors++;
    if (CAR_SWITCHES !== 2'b10) begin
      miscompares++;
      $display("FAIL car_write: got %b required 10", CAR_SWITCHES);
    end
    bus_read(8'h90, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h03) begin
      miscompares++;
      $display("FAIL cmd_read: got v=%b d=%h required v=1 d=03", v, d);
    end
    @(negedge CLK);
    vectors++;
    if (BUS_RVALID !== 1'b0 || BUS_RDATA !== 8'h00) begin
      miscompares++;
      $display("FAIL rvalid_one_cycle: got v=%b d=%h required v=0 d=00", BUS_RVALID, BUS_RDATA);
    end
    bus_read(8'h91, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h02) begin
      miscompares++;
      $display("FAIL car_read: got v=%b d=%h required v=1 d=02", v, d);
    end
  endtask

  task automatic test_bus_boundary();
    logic [7:0] d;
    logic       v;
    bus_write(8'h95, 8'hFF);
    bus_read(8'h95, d, v);
    vectors++;
    if (v !== 1'b0 || d !== 8'h00) begin
      miscompares++;
      $display("FAIL out_of_range_hi: got v=%b d=%h required v=0 d=00", v, d);
    end
    bus_read(8'h8F, d, v);
    vectors++;
    if (v !== 1'b0 || d !== 8'h00) begin
      miscompares++;
      $display("FAIL out_of_range_lo: got v=%b d=%h required v=0 d=00", v, d);
    end
    bus_write(8'h93, 8'hFF);
    bus_read(8'h93, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h00) begin
      miscompares++;
      $display("FAIL status_readonly: got v=%b d=%h required v=1 d=00", v, d);
    end
    bus_write(8'h92, 8'hFE);
    bus_read(8'h92, d, v);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL ctrl_ack_reads_0: got %h required 00", d);
    end
    // Same-cycle write and read of TMO: read sees the old value.
    BUS_ADDR = 8'h94; BUS_WDATA = 8'h10; BUS_WE = 1'b1; BUS_RE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0; BUS_RE = 1'b0;
    vectors++;
    if (BUS_RVALID !== 1'b1 || BUS_RDATA !== 8'h64) begin
      miscompares++;
      $display("FAIL wr_rd_same_cycle: got v=%b d=%h required v=1 d=64", BUS_RVALID, BUS_RDATA);
    end
    bus_read(8'h94, d, v);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++;
      $display("FAIL tmo_after_write: got %h required 10", d);
    end
  endtask

  task automatic test_expiry();
    logic [7:0] d;
    logic       v;
    int         n;
    bus_write(8'h94, 8'h03);
    bus_write(8'h92, 8'h01);
    bus_write(8'h90, 8'h09);
    vectors++;
    if (COMMAND !== 4'h9) begin
      miscompares++;
      $display("FAIL expiry_cmd_load: got %h required 9", COMMAND);
    end
    n = 0;
    while (COMMAND !== 4'h0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (n < 21 || n > 31) begin
      miscompares++;
      $display("FAIL expiry_latency: got %0d cycles required 21..31", n);
    end
    vectors++;
    if (TIMEOUT_IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL expiry_irq: got %b required 1", TIMEOUT_IRQ);
    end
    bus_read(8'h93, d, v);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL expiry_status: got %h required 01", d);
    end
  endtask

  task automatic test_refresh();
    int bad = 0;
    bus_write(8'h92, 8'h03);
    vectors++;
    if (TIMEOUT_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL refresh_ack: got %b required 0", TIMEOUT_IRQ);
    end
    bus_write(8'h90, 8'h09);
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 14) bus_write(8'h90, 8'h09);
      else              @(negedge CLK);
      if (COMMAND !== 4'h9 || TIMEOUT_IRQ !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL refresh_hold: got %0d bad cycles required 0", bad);
    end
  endtask

  // After reset the prescaler ticks on edges 10, 20, 30, 40 ...
  // TMO=2, armed at edge 3: without refresh the expiry lands on edge 20.
  task automatic test_simultaneous();
    logic [7:0] d;
    logic       v;
    pulse_reset();
    bus_write(8'h94, 8'h02);
    bus_write(8'h92, 8'h01);
    bus_write(8'h90, 8'h09);
    wait_cyc(19);
    vectors++;
    if (COMMAND !== 4'h9 || TIMEOUT_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_tick20: got cmd=%h irq=%b required cmd=9 irq=0", COMMAND, TIMEOUT_IRQ);
    end
    bus_write(8'h90, 8'h07);
    vectors++;
    if (COMMAND !== 4'h7 || TIMEOUT_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_on_expiry: got cmd=%h irq=%b required cmd=7 irq=0", COMMAND, TIMEOUT_IRQ);
    end
    wait_cyc(39);
    vectors++;
    if (COMMAND !== 4'h7 || TIMEOUT_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_tick40: got cmd=%h irq=%b required cmd=7 irq=0", COMMAND, TIMEOUT_IRQ);
    end
    bus_write(8'h92, 8'h03);
    vectors++;
    if (COMMAND !== 4'h0 || TIMEOUT_IRQ !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_on_expiry: got cmd=%h irq=%b required cmd=0 irq=1", COMMAND, TIMEOUT_IRQ);
    end
    bus_read(8'h93, d, v);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL ack_on_expiry_status: got %h required 01", d);
    end
  endtask

  task automatic test_recovery();
    logic [7:0] d;
    logic       v;
    bus_write(8'h90, 8'h02);
    vectors++;
    if (COMMAND !== 4'h2 || TIMEOUT_IRQ !== 1'b1 || debug_state !== WD_ARMED) begin
      miscompares++;
      $display("FAIL recover_cmd: got cmd=%h irq=%b st=%0d required cmd=2 irq=1 st=1",
               COMMAND, TIMEOUT_IRQ, debug_state);
    end
    bus_read(8'h93, d, v);
    vectors++;
    if (d !== 8'h03) begin
      miscompares++;
      $display("FAIL recover_status: got %h required 03", d);
    end
    bus_write(8'h92, 8'h03);
    vectors++;
    if (TIMEOUT_IRQ !== 1'b0) begin
      miscompares++;
      $display("FAIL recover_ack: got %b required 0", TIMEOUT_IRQ);
    end
    bus_write(8'h92, 8'h00);
    @(negedge CLK);
    bus_read(8'h93, d, v);
    vectors++;
    if (d !== 8'h00 || debug_state !== WD_IDLE) begin
      miscompares++;
      $display("FAIL disable_status: got d=%h st=%0d required d=00 st=0", d, debug_state);
    end
    vectors++;
    if (COMMAND !== 4'h2) begin
      miscompares++;
      $display("FAIL disable_keeps_cmd: got %h required 2", COMMAND);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_writes();
    test_bus_boundary();
    test_expiry();
    test_refresh();
    test_simultaneous();
    test_recovery();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
